// File: rtl/spi_aes_slave_pkg.sv
// Shared types and frame-geometry helpers for the SPI front-end of the AES cores.
// Pure declarations: no logic, no latency, no flow control.
package aes_spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        LAUNCH = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic [7:0] CMD_ENC = 8'h00;
    localparam logic [7:0] CMD_DEC = 8'h01;

    // Command byte, then 128-bit block, then the Nk-word key.
    function automatic int frame_bits(input int nk);
        return 8 + 128 + nk * 32;
    endfunction

    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/spi_aes_slave_if.sv
// Core-side bundle between the SPI front-end (master) and the encrypt/decrypt cores (slave).
// Starts and done are single-cycle pulses; the cores cannot push back on a launch.
interface spi_aes_slave_if #(
    parameter int NK = 4
);
    logic [127:0]    data_out;
    logic [NK*32-1:0] key_out;
    logic            enc_start;
    logic            dec_start;
    logic            enc_done;
    logic            dec_done;
    logic [127:0]    enc_result;
    logic [127:0]    dec_result;
    logic            busy;
    logic            done;
    logic            frame_err;

    modport master (
        output data_out, key_out, enc_start, dec_start, busy, done, frame_err,
        input  enc_done, dec_done, enc_result, dec_result
    );

    modport slave (
        input  data_out, key_out, enc_start, dec_start, busy, done, frame_err,
        output enc_done, dec_done, enc_result, dec_result
    );
endinterface

// File: rtl/spi_aes_slave_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with rise/fall strobes on the synced level.
// Latency: level valid 2 clk after the pin, strobes combinational from that; no backpressure.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;
endmodule

// File: rtl/spi_aes_slave.sv
// SPI mode-0 slave front-end for the AES cores; optional WAIT watchdog via SPI_AES_TIMEOUT_EN.
// Latency: 3 clk from pin to action; no backpressure, frames arriving while busy are rejected.
module spi_aes_slave
    import aes_spi_pkg::*;
#(
    parameter int Nk          = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    spi_aes_slave_if.master core
);
    localparam int FB = frame_bits(Nk);
    localparam int CW = cnt_width(FB);
    localparam int KW = Nk * 32;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .din(cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .din(mosi), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_edges = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    state_t        state;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [FB-1:0] shift, shift_nxt;
    logic [127:0]  result;
    logic [127:0]  miso_sr;
    logic          sel;
    logic          busy_frame;
    logic [7:0]    cmd;
    logic          frame_ok;

`ifdef SPI_AES_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;
`else
    localparam int unused_timeout = TIMEOUT_CYC;
`endif

    // The sclk edge is folded in before the cs_n-rise decision so a coincident last bit counts.
    always_comb begin
        cnt_nxt   = cnt;
        shift_nxt = shift;
        if (state == RECV && sclk_rise && cnt != CW'(FB)) begin
            cnt_nxt   = cnt + CW'(1);
            shift_nxt = {shift[FB-2:0], mosi_s};
        end
    end

    assign cmd      = shift_nxt[FB-1 -: 8];
    assign frame_ok = (cnt_nxt == CW'(FB)) && (cmd == CMD_ENC || cmd == CMD_DEC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            shift          <= '0;
            result         <= '0;
            miso_sr        <= '0;
            miso           <= 1'b0;
            sel            <= 1'b0;
            busy_frame     <= 1'b0;
            core.data_out  <= '0;
            core.key_out   <= '0;
            core.enc_start <= 1'b0;
            core.dec_start <= 1'b0;
            core.busy      <= 1'b0;
            core.done      <= 1'b0;
            core.frame_err <= 1'b0;
`ifdef SPI_AES_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            core.enc_start <= 1'b0;
            core.dec_start <= 1'b0;
            core.done      <= 1'b0;
            core.frame_err <= 1'b0;

            // A frame opened while a launch is outstanding is swallowed and reported at its end.
            if (cs_fall && (state == LAUNCH || state == WAIT))
                busy_frame <= 1'b1;
            if (cs_rise && busy_frame) begin
                busy_frame     <= 1'b0;
                core.frame_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= RECV;
                        cnt     <= '0;
                        miso_sr <= result;
                        miso    <= 1'b0;
                    end
                end
                RECV: begin
                    cnt   <= cnt_nxt;
                    shift <= shift_nxt;
                    if (sclk_fall) begin
                        if (cnt >= CW'(8) && cnt < CW'(136)) begin
                            miso    <= miso_sr[127];
                            miso_sr <= {miso_sr[126:0], 1'b0};
                        end else begin
                            miso <= 1'b0;
                        end
                    end
                    if (cs_rise) begin
                        miso <= 1'b0;
                        if (frame_ok) begin
                            state          <= LAUNCH;
                            core.data_out  <= shift_nxt[FB-9 -: 128];
                            core.key_out   <= shift_nxt[KW-1:0];
                            core.enc_start <= (cmd == CMD_ENC);
                            core.dec_start <= (cmd == CMD_DEC);
                            core.busy      <= 1'b1;
                            sel            <= (cmd == CMD_DEC);
                        end else begin
                            state          <= IDLE;
                            core.frame_err <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
`ifdef SPI_AES_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (sel ? core.dec_done : core.enc_done) begin
                        result    <= sel ? core.dec_result : core.enc_result;
                        core.done <= 1'b1;
                        core.busy <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef SPI_AES_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        core.frame_err <= 1'b1;
                        core.busy      <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_aes_slave.sv
// Directed bench for spi_aes_slave: Nk=4 and Nk=8 instances driven over a shared sclk/mosi.
// Table of frames with hand-computed results, then busy/timeout/reset corner sequences.
`timescale 1ns/1ps
module tb_spi_aes_slave;
    localparam int HALF = 4;
    localparam logic [255:0] K4 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic reset, sclk, mosi, cs_n4, cs_n8, miso4, miso8;
    always #5 clk = ~clk;

    spi_aes_slave_if #(.NK(4)) if4 ();
    spi_aes_slave_if #(.NK(8)) if8 ();

    spi_aes_slave #(.Nk(4), .TIMEOUT_CYC(1024)) dut4 (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n4), .mosi(mosi), .miso(miso4), .core(if4.master));
    spi_aes_slave #(.Nk(8), .TIMEOUT_CYC(1024)) dut8 (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n8), .mosi(mosi), .miso(miso8), .core(if8.master));

    int es[2], ds[2], fe[2], dn[2];
    int cyc, start_cyc, fe_cyc;
    int n_cmp, n_err;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (if4.enc_start) begin es[0] <= es[0] + 1; start_cyc <= cyc; end
        if (if4.dec_start) ds[0] <= ds[0] + 1;
        if (if4.frame_err) begin fe[0] <= fe[0] + 1; fe_cyc <= cyc; end
        if (if4.done)      dn[0] <= dn[0] + 1;
        if (if8.enc_start) es[1] <= es[1] + 1;
        if (if8.dec_start) ds[1] <= ds[1] + 1;
        if (if8.frame_err) fe[1] <= fe[1] + 1;
        if (if8.done)      dn[1] <= dn[1] + 1;
    end

    typedef struct {
        int           s;
        logic [7:0]   cmd;
        logic [127:0] blk;
        logic [255:0] key;
        int           n;
        bit           coinc;
        bit           acc;
        logic [127:0] res;
    } vec_t;
    vec_t vt[8];

    logic [127:0] exp_res[2];
    logic [127:0] exp_data[2];
    logic [255:0] exp_key[2];

    task automatic chk(input string nm, input logic [391:0] act, input logic [391:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_set(input int s, input logic v);
        if (s == 0) cs_n4 = v; else cs_n8 = v;
    endtask

    function automatic logic get_miso(input int s);
        return (s == 0) ? miso4 : miso8;
    endfunction
    function automatic logic [127:0] get_data(input int s);
        return (s == 0) ? if4.data_out : if8.data_out;
    endfunction
    function automatic logic [255:0] get_key(input int s);
        return (s == 0) ? {128'h0, if4.key_out} : if8.key_out;
    endfunction
    function automatic logic get_busy(input int s);
        return (s == 0) ? if4.busy : if8.busy;
    endfunction

    function automatic logic [391:0] mk_tx(input int s, input logic [7:0] cmd,
                                           input logic [127:0] blk, input logic [255:0] key);
        return (s == 0) ? {cmd, blk, key[127:0], 128'h0} : {cmd, blk, key};
    endfunction

    // Status byte, then the result MSB first, then zeros; bits past the frame length never arrive.
    function automatic logic [391:0] exp_miso(input logic [127:0] res, input int n);
        logic [391:0] e;
        e = {8'h00, res, 256'h0};
        for (int i = n; i < 392; i++) e[391-i] = 1'b0;
        return e;
    endfunction

    task automatic send_bits(input int s, input logic [391:0] tx, input int n, input bit coinc,
                             inout logic [391:0] rx);
        for (int i = 0; i < n; i++) begin
            mosi = tx[391-i];
            tick(HALF);
            rx[391-i] = get_miso(s);
            sclk = 1'b1;
            if (coinc && i == n - 1) cs_set(s, 1'b1);
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int s, input logic [391:0] tx, input int n, input bit coinc,
                             output logic [391:0] rx);
        rx = '0;
        cs_set(s, 1'b0);
        tick(HALF);
        send_bits(s, tx, n, coinc, rx);
        tick(HALF);
        cs_set(s, 1'b1);
        tick(8);
    endtask

    task automatic set_core(input int s, input bit dec, input logic v, input logic [127:0] res);
        if (s == 0) begin
            if (dec) begin if4.dec_result = res; if4.dec_done = v; end
            else begin if4.enc_result = res; if4.enc_done = v; end
        end else begin
            if (dec) begin if8.dec_result = res; if8.dec_done = v; end
            else begin if8.enc_result = res; if8.enc_done = v; end
        end
    endtask

    task automatic deliver(input int s, input bit dec, input logic [127:0] res);
        set_core(s, dec, 1'b1, res);
        tick(1);
        set_core(s, dec, 1'b0, res);
        tick(4);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_data4"}, if4.data_out, 0);
        chk({nm, "_key4"}, if4.key_out, 0);
        chk({nm, "_pulses4"}, {if4.enc_start, if4.dec_start, if4.busy, if4.done, if4.frame_err, miso4}, 0);
        chk({nm, "_data8"}, if8.data_out, 0);
        chk({nm, "_key8"}, if8.key_out, 0);
        chk({nm, "_pulses8"}, {if8.enc_start, if8.dec_start, if8.busy, if8.done, if8.frame_err, miso8}, 0);
    endtask

    initial begin
        logic [391:0] rx;
        int es0, ds0, fe0, dn0, k;

        vt[0] = '{0, 8'h00, 128'h00112233445566778899aabbccddeeff, K4, 264, 1'b0, 1'b1,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[1] = '{1, 8'h01, 128'h8ea2b7ca516745bfeafc49904b496089, K8, 392, 1'b0, 1'b1,
                  128'h00112233445566778899aabbccddeeff};
        vt[2] = '{0, 8'h00, 128'hffeeddccbbaa99887766554433221100, K4, 100, 1'b0, 1'b0, 128'h0};
        vt[3] = '{0, 8'h02, 128'h0123456789abcdef0123456789abcdef, K4, 264, 1'b0, 1'b0, 128'h0};
        vt[4] = '{0, 8'h01, 128'hdeadbeefcafef00d0123456789abcdef,
                  256'h0f0e0d0c0b0a09080706050403020100, 300, 1'b0, 1'b1,
                  128'h1234567890abcdef1122334455667788};
        vt[5] = '{1, 8'h80, 128'h1, K8, 392, 1'b0, 1'b0, 128'h0};
        vt[6] = '{1, 8'h01, 128'h2, K8, 391, 1'b0, 1'b0, 128'h0};
        vt[7] = '{0, 8'h00, 128'hfedcba98765432100123456789abcdef, K4, 264, 1'b1, 1'b1,
                  128'hcafebabe0badf00d5555aaaa3333cccc};

        reset = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n4 = 1'b1; cs_n8 = 1'b1;
        set_core(0, 1'b0, 1'b0, 128'h0); set_core(0, 1'b1, 1'b0, 128'h0);
        set_core(1, 1'b0, 1'b0, 128'h0); set_core(1, 1'b1, 1'b0, 128'h0);
        for (int s = 0; s < 2; s++) begin exp_res[s] = '0; exp_data[s] = '0; exp_key[s] = '0; end
        tick(3);
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick(4);

        for (int v = 0; v < 8; v++) begin
            int s;
            bit dec;
            s = vt[v].s;
            dec = vt[v].cmd[0];
            es0 = es[s]; ds0 = ds[s]; fe0 = fe[s]; dn0 = dn[s];
            spi_frame(s, mk_tx(s, vt[v].cmd, vt[v].blk, vt[v].key), vt[v].n, vt[v].coinc, rx);
            chk($sformatf("v%0d_miso", v), rx, exp_miso(exp_res[s], vt[v].n));
            if (vt[v].acc) begin
                chk($sformatf("v%0d_enc_start", v), es[s] - es0, dec ? 0 : 1);
                chk($sformatf("v%0d_dec_start", v), ds[s] - ds0, dec ? 1 : 0);
                chk($sformatf("v%0d_frame_err", v), fe[s] - fe0, 0);
                chk($sformatf("v%0d_data_out", v), get_data(s), vt[v].blk);
                chk($sformatf("v%0d_key_out", v), get_key(s),
                    (s == 0) ? {128'h0, vt[v].key[127:0]} : vt[v].key);
                chk($sformatf("v%0d_busy", v), get_busy(s), 1);
                deliver(s, dec, vt[v].res);
                chk($sformatf("v%0d_done", v), dn[s] - dn0, 1);
                chk($sformatf("v%0d_busy_clr", v), get_busy(s), 0);
                exp_res[s]  = vt[v].res;
                exp_data[s] = vt[v].blk;
            end else begin
                chk($sformatf("v%0d_frame_err", v), fe[s] - fe0, 1);
                chk($sformatf("v%0d_no_start", v), (es[s] - es0) + (ds[s] - ds0), 0);
                chk($sformatf("v%0d_data_kept", v), get_data(s), exp_data[s]);
                chk($sformatf("v%0d_idle", v), get_busy(s), 0);
            end
        end

        // Frame during WAIT, plus the non-selected core's done being ignored.
        es0 = es[0]; dn0 = dn[0];
        spi_frame(0, mk_tx(0, 8'h00, 128'h11112222333344445555666677778888, K4), 264, 1'b0, rx);
        chk("wait_first_miso", rx, exp_miso(exp_res[0], 264));
        chk("wait_first_start", es[0] - es0, 1);
        deliver(0, 1'b1, 128'hbadbadbadbadbadbadbadbadbadbad00);
        chk("wait_other_done", dn[0] - dn0, 0);
        chk("wait_other_busy", if4.busy, 1);
        fe0 = fe[0]; es0 = es[0];
        spi_frame(0, mk_tx(0, 8'h00, 128'h99999999999999999999999999999999, K4), 60, 1'b0, rx);
        chk("busy_frame_miso", rx, 0);
        chk("busy_frame_err", fe[0] - fe0, 1);
        chk("busy_frame_start", es[0] - es0, 0);
        chk("busy_frame_busy", if4.busy, 1);
        chk("busy_frame_data", if4.data_out, 128'h11112222333344445555666677778888);
        deliver(0, 1'b0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        chk("wait_done", dn[0] - dn0, 1);
        exp_res[0] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

        // Watchdog, or indefinite WAIT in the default build.
        es0 = es[0]; fe0 = fe[0]; dn0 = dn[0];
        spi_frame(0, mk_tx(0, 8'h00, 128'h0123, K4), 264, 1'b0, rx);
        chk("wd_miso", rx, exp_miso(exp_res[0], 264));
        chk("wd_start", es[0] - es0, 1);
`ifdef SPI_AES_TIMEOUT_EN
        k = 0;
        while (fe[0] == fe0 && k < 2000) begin tick(1); k++; end
        chk("wd_fired", fe[0] - fe0, 1);
        chk("wd_cycles_from_launch", fe_cyc - start_cyc, 1025);
        chk("wd_busy", if4.busy, 0);
        chk("wd_no_done", dn[0] - dn0, 0);
        spi_frame(0, mk_tx(0, 8'h02, 128'h0, K4), 264, 1'b0, rx);
        chk("wd_result_kept", rx, exp_miso(exp_res[0], 264));
`else
        k = 0;
        tick(1100);
        chk("hold_busy", if4.busy, 1);
        chk("hold_no_err", fe[0] - fe0, 0);
        deliver(0, 1'b0, 128'h00000000ffffffff00000000ffffffff);
        chk("hold_done", dn[0] - dn0, 1);
        exp_res[0] = 128'h00000000ffffffff00000000ffffffff;
`endif

        // Reset in the middle of a frame.
        rx = '0;
        cs_set(0, 1'b0);
        tick(HALF);
        send_bits(0, mk_tx(0, 8'h00, 128'h5a5a, K4), 50, 1'b0, rx);
        reset = 1'b1;
        tick(1);
        chk_reset_outputs("rst_recv");
        cs_n4 = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);
        for (int s = 0; s < 2; s++) begin exp_res[s] = '0; exp_data[s] = '0; end

        // Reset while waiting on the core after a non-zero result was stored.
        spi_frame(0, mk_tx(0, 8'h00, 128'h77, K4), 264, 1'b0, rx);
        chk("rst_wait_pre_miso", rx, exp_miso(exp_res[0], 264));
        deliver(0, 1'b0, 128'hffff0000ffff0000ffff0000ffff0000);
        exp_res[0] = 128'hffff0000ffff0000ffff0000ffff0000;
        spi_frame(0, mk_tx(0, 8'h00, 128'h88, K4), 264, 1'b0, rx);
        chk("rst_wait_miso", rx, exp_miso(exp_res[0], 264));
        chk("rst_wait_busy", if4.busy, 1);
        reset = 1'b1;
        tick(1);
        chk_reset_outputs("rst_wait");
        tick(2);
        reset = 1'b0;
        tick(4);
        exp_res[0] = '0;
        spi_frame(0, mk_tx(0, 8'h02, 128'h0, K4), 264, 1'b0, rx);
        chk("rst_wait_result_cleared", rx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
